// File: rtl/out_rd_controller_fsm_pkg.sv
// Shared constants and state encoding for the output-port read controller.
// Optional length checking is enabled with the OUT_RD_LEN_CHECK_EN macro.
package out_rd_controller_fsm_pkg;

    localparam int DATA_WIDTH_DEF   = 16;
    localparam int DATA_LENGTH_MAX  = 12;
    localparam int WIDTH_LENGTH_DEF = $clog2(DATA_LENGTH_MAX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOP,
        ST_CTRL,
        ST_DATA,
        ST_DRAIN,
        ST_EOP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/out_rd_controller_fsm_beat_counter.sv
// Payload beat counter: clears at end of frame, counts issued reads and
// flags the read that fetches the final beat of the frame.
module out_rd_beat_counter #(
    parameter int WIDTH_LENGTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    inc,
    input  logic [WIDTH_LENGTH-1:0] len,
    output logic                    last
);

    logic [WIDTH_LENGTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + WIDTH_LENGTH'(1);
        end
    end

    // Only consulted in DATA, which is never entered with len == 0
    assign last = (cnt == len - WIDTH_LENGTH'(1));

endmodule

// File: rtl/out_rd_controller_fsm.sv
// Output-port read controller: pops a descriptor, streams its payload out of
// the shared cache as sop/ctrl/data/eop. Macro OUT_RD_LEN_CHECK_EN adds length checking.
//
// state | meaning
// IDLE  | waiting for a descriptor
// SOP   | sop pulse, pop and latch descriptor
// CTRL  | control word on data_out
// DATA  | issue cache reads unless held
// DRAIN | last read in flight, final beat presented
// EOP   | eop pulse
// DONE  | done pulse, reset CRC, clear beat counter
module out_rd_controller_fsm
    import out_rd_controller_fsm_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int WIDTH_LENGTH = WIDTH_LENGTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  desc_empty,
    input  logic [DATA_WIDTH-1:0] desc_data,
    output logic                  desc_rd,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  tx_hold,
    output logic                  sop,
    output logic                  valid,
    output logic                  eop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [DATA_WIDTH-1:0] ctrl_data_reg,
    output logic                  busy,
    output logic                  done,
    output logic                  crc_rst_n,
    output logic                  err
);

    state_t                  state_q, state_d;
    logic                    rd_en_q;
    logic                    crc_rst;
    logic                    cnt_clr;
    logic                    last_beat;
    logic [WIDTH_LENGTH-1:0] len;

    assign len = ctrl_data_reg[WIDTH_LENGTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ctrl_data_reg <= '0;
            rd_en_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_en_q <= rd_en;
            if (state_q == ST_SOP) begin
                ctrl_data_reg <= desc_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sop     = 1'b0;
        desc_rd = 1'b0;
        rd_en   = 1'b0;
        eop     = 1'b0;
        done    = 1'b0;
        crc_rst = 1'b0;
        cnt_clr = 1'b0;
        err     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!desc_empty) state_d = ST_SOP;
            end
            ST_SOP: begin
                sop     = 1'b1;
                desc_rd = 1'b1;
                state_d = ST_CTRL;
            end
            ST_CTRL: begin
`ifdef OUT_RD_LEN_CHECK_EN
                // Abort after sop: receiver sees a frame with no eop
                if (len == '0 || 32'(len) > DATA_LENGTH_MAX) begin
                    err     = 1'b1;
                    crc_rst = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                end
`else
                state_d = (len == '0) ? ST_EOP : ST_DATA;
`endif
            end
            ST_DATA: begin
                rd_en = !tx_hold;
                if (rd_en && last_beat) state_d = ST_DRAIN;
            end
            ST_DRAIN: state_d = ST_EOP;
            ST_EOP: begin
                eop     = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                crc_rst = 1'b1;
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    out_rd_beat_counter #(
        .WIDTH_LENGTH(WIDTH_LENGTH)
    ) u_beat_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (cnt_clr),
        .inc  (rd_en),
        .len  (len),
        .last (last_beat)
    );

    assign valid     = rd_en_q;
    assign busy      = (state_q != ST_IDLE);
    assign crc_rst_n = rst_n & !crc_rst;

    always_comb begin
        data_out = '0;
        if (state_q == ST_CTRL) begin
            data_out = ctrl_data_reg;
        end else if (valid) begin
            data_out = rd_data;
        end
    end

endmodule

// File: tb/tb_out_rd_controller_fsm.sv
// Scoreboard bench for out_rd_controller_fsm: descriptors and cache payload are
// generated here, expected frame events are queued at issue time and matched by a monitor.
module tb_out_rd_controller_fsm;
    import out_rd_controller_fsm_pkg::*;

    localparam int DW = DATA_WIDTH_DEF;
    localparam int K_SOP = 0, K_CTRL = 1, K_BEAT = 2, K_EOP = 3, K_DONE = 4, K_ERR = 5;

    typedef struct {int id; int kind; logic [DW-1:0] data;} ev_t;
    typedef struct {int id; logic [DW-1:0] data;} beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          desc_empty;
    logic [DW-1:0] desc_data;
    logic          desc_rd;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          tx_hold;
    logic          sop, valid, eop, busy, done, crc_rst_n, err;
    logic [DW-1:0] data_out, ctrl_data_reg;

    out_rd_controller_fsm dut (
        .clk(clk), .rst_n(rst_n), .desc_empty(desc_empty), .desc_data(desc_data),
        .desc_rd(desc_rd), .rd_en(rd_en), .rd_data(rd_data), .tx_hold(tx_hold),
        .sop(sop), .valid(valid), .eop(eop), .data_out(data_out),
        .ctrl_data_reg(ctrl_data_reg), .busy(busy), .done(done),
        .crc_rst_n(crc_rst_n), .err(err)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0, total_cnt = 0;
    ev_t exp_q[$];
    beat_t cache_q[$];
    logic [DW-1:0] dq[$];
    int next_id = 0, cur_id = -1;
    int cyc = 0, last_done_cyc = 0, last_gap = 0;
    int n_valid = 0, n_eop = 0, n_err = 0, n_desc_rd = 0;
    logic prev_sop = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic bit bad_len(input int len);
`ifdef OUT_RD_LEN_CHECK_EN
        return (len == 0 || len > DATA_LENGTH_MAX);
`else
        return 1'b0;
`endif
    endfunction

    // Reference: a frame is sop, ctrl word, L beats in order, eop, done (or err abort)
    task automatic push_desc(input int len, output logic [DW-1:0] d);
        logic [DW-1:0] r;
        int id;
        id = next_id++;
        r = DW'($urandom());
        d = r;
        d[WIDTH_LENGTH_DEF-1:0] = WIDTH_LENGTH_DEF'(len);
        exp_q.push_back('{id, K_SOP, '0});
        exp_q.push_back('{id, K_CTRL, d});
        if (bad_len(len)) begin
            exp_q.push_back('{id, K_ERR, '0});
        end else begin
            for (int i = 0; i < len; i++) begin
                r = DW'($urandom());
                cache_q.push_back('{id, r});
                exp_q.push_back('{id, K_BEAT, r});
            end
            exp_q.push_back('{id, K_EOP, '0});
            exp_q.push_back('{id, K_DONE, '0});
        end
        dq.push_back(d);
        desc_empty = 1'b0;
        desc_data  = dq[0];
    endtask

    task automatic sb_match(input int kind, input logic [DW-1:0] data);
        ev_t e;
        total_cnt++;
        if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected: got kind %0d data %0h required no event (cycle %0d)", kind, data, cyc);
        end else begin
            e = exp_q.pop_front();
            cur_id = e.id;
            if (e.kind == kind && e.data === data) pass_cnt++;
            else $display("FAIL sb_event: got kind %0d data %0h required kind %0d data %0h (cycle %0d)",
                          kind, data, e.kind, e.data, cyc);
        end
    endtask

    // Descriptor FIFO (first-word fall-through) and shared cache with 1-cycle read latency
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && desc_rd && dq.size() > 0) void'(dq.pop_front());
        desc_empty <= (dq.size() == 0);
        desc_data  <= (dq.size() > 0) ? dq[0] : '0;
        if (rd_en) begin
            if (cache_q.size() > 0) begin
                rd_data <= cache_q[0].data;
                void'(cache_q.pop_front());
            end else begin
                rd_data <= 16'hDEAD;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_sop = 1'b0;
        end else begin
            if (desc_rd) n_desc_rd++;
            if (sop || desc_rd) check("desc_rd_with_sop", desc_rd, sop);
            if (sop) begin
                sb_match(K_SOP, '0);
                last_gap = cyc - last_done_cyc;
            end
            if (prev_sop) sb_match(K_CTRL, data_out);
            if (valid) begin
                n_valid++;
                sb_match(K_BEAT, data_out);
            end
            if (eop) begin
                n_eop++;
                sb_match(K_EOP, '0);
            end
            if (done) begin
                last_done_cyc = cyc;
                sb_match(K_DONE, '0);
                check("crc_rst_n_at_done", crc_rst_n, 0);
            end
            if (err) begin
                n_err++;
                sb_match(K_ERR, '0);
                check("crc_rst_n_at_err", crc_rst_n, 0);
            end
            prev_sop = sop;
        end
    end

    task automatic wait_drain(input string name);
        int c;
        for (c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && dq.size() == 0 && !busy) break;
        end
        if (c == 4000) check({name, "_timeout"}, exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic wait_reads(input int n, input string name);
        int k = 0;
        int c;
        for (c = 0; c < 200 && k < n; c++) begin
            @(negedge clk);
            if (rd_en) k++;
        end
        if (k < n) check({name, "_rd_timeout"}, k, n);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, {sop, valid, eop, desc_rd, rd_en, busy, done, err, crc_rst_n}, 0);
        check({name, "_data_out"}, data_out, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish required finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d, d2;
        int b_valid, b_eop, b_err, b_drd;
        rst_n = 1'b0; tx_hold = 1'b0; desc_empty = 1'b1; desc_data = '0; rd_data = '0;
        #1;
        check_all_zero("reset");
        check("reset_ctrl_reg", ctrl_data_reg, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_crc_rst_n", crc_rst_n, 1);
        check("post_reset_busy", busy, 0);

        // L=3 exact cycle timing
        @(negedge clk);
        push_desc(3, d);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check($sformatf("t%0d_sop", k), sop, k == 1);
            check($sformatf("t%0d_valid", k), valid, k >= 4 && k <= 6);
            check($sformatf("t%0d_eop", k), eop, k == 7);
            check($sformatf("t%0d_done", k), done, k == 8);
            check($sformatf("t%0d_crc_rst_n", k), crc_rst_n, k != 8);
            check($sformatf("t%0d_busy", k), busy, k <= 8);
            if (k == 2) check("t2_ctrl_word", data_out, d);
            if (k == 3) check("t3_first_rd_en", rd_en, 1);
        end
        check("l3_ctrl_reg", ctrl_data_reg, d);

        // L=5 with tx_hold for two cycles after the second read
        b_valid = n_valid; b_eop = n_eop;
        push_desc(5, d);
        wait_reads(2, "hold");
        @(posedge clk); #1 tx_hold = 1'b1;
        @(negedge clk);
        check("hold_c1_rd_en", rd_en, 0);
        check("hold_inflight_beat", valid, 1);
        @(negedge clk);
        check("hold_c2_rd_en", rd_en, 0);
        check("hold_c2_valid", valid, 0);
        @(posedge clk); #1 tx_hold = 1'b0;
        wait_drain("hold");
        check("hold_beats", n_valid - b_valid, 5);
        check("hold_eops", n_eop - b_eop, 1);

        // L=0
        b_valid = n_valid; b_eop = n_eop; b_err = n_err;
        push_desc(0, d);
        wait_drain("len0");
        check("len0_beats", n_valid - b_valid, 0);
        check("len0_eops", n_eop - b_eop, bad_len(0) ? 0 : 1);
        check("len0_errs", n_err - b_err, bad_len(0) ? 1 : 0);
        check("len0_idle", busy, 0);

        // Back-to-back L=1, L=2
        b_drd = n_desc_rd; b_valid = n_valid;
        push_desc(1, d);
        push_desc(2, d2);
        wait_drain("b2b");
        check("b2b_desc_rd", n_desc_rd - b_drd, 2);
        check("b2b_beats", n_valid - b_valid, 3);
        check("b2b_gap", last_gap, 2);

        // Reset during DATA of an L=8 frame, L=2 queued behind it
        b_valid = n_valid;
        push_desc(8, d);
        push_desc(2, d2);
        wait_reads(3, "rst");
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i].id == cur_id) exp_q.delete(i);
        for (int i = cache_q.size() - 1; i >= 0; i--) if (cache_q[i].id == cur_id) cache_q.delete(i);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_drain("after_reset");
        check("after_reset_ctrl_reg", ctrl_data_reg, d2);

        // Maximum length
        b_valid = n_valid; b_eop = n_eop;
        push_desc(DATA_LENGTH_MAX, d);
        wait_drain("max_len");
        check("max_len_beats", n_valid - b_valid, DATA_LENGTH_MAX);
        check("max_len_eops", n_eop - b_eop, 1);

        // Randomized lengths and stalls
        for (int f = 0; f < 25; f++) push_desc($urandom_range(0, 15), d);
        for (int c = 0; c < 5000 && (exp_q.size() > 0 || dq.size() > 0 || busy); c++) begin
            @(negedge clk);
            tx_hold = ($urandom_range(0, 3) == 0);
        end
        tx_hold = 1'b0;
        wait_drain("random");

        check("sb_leftover_events", exp_q.size(), 0);
        check("leftover_cache_beats", cache_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/out_rd_controller_fsm.md
Name: out_rd_controller_fsm

Overview:
Output-port read controller for the shared-cache switch. It is the transmit counterpart of the input write controller.
- Pops a packet descriptor and reads the packet's payload beats out of the shared cache.
- Emits a frame on the output port in the same framing the input side accepts: sop cycle, control-word cycle, L valid data beats, eop cycle.
- Pulses done and resets the output CRC at end of frame.

Parameters:
DATA_WIDTH, `DATA_WIDTH (generate_parameter.vh), data/control word width.
WIDTH_LENGTH, $clog2(`DATA_LENGTH_MAX), width of the length field and the beat counter.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
desc_empty  in  1  descriptor queue empty
desc_data  in  DATA_WIDTH  head descriptor (FWFT); bits [WIDTH_LENGTH-1:0] = payload length L
desc_rd  out  1  one-cycle pop of descriptor queue
rd_en  out  1  shared-cache read request; data returns next cycle
rd_data  in  DATA_WIDTH  shared-cache read data (1-cycle latency)
tx_hold  in  1  downstream stall; blocks new reads
sop  out  1  start-of-packet pulse
valid  out  1  payload beat on data_out
eop  out  1  end-of-packet pulse (no data)
data_out  out  DATA_WIDTH  control word during CTRL, rd_data when valid, else 0
ctrl_data_reg  out  DATA_WIDTH  latched descriptor
busy  out  1  state != IDLE
done  out  1  frame complete pulse
crc_rst_n  out  1  rst_n & !crc_rst
err  out  1  bad-descriptor pulse (optional feature; tied 0 otherwise)

Behaviour:
- Clocking/reset: single clock clk; reset rst_n asynchronous active-low.
- Reset values: state=IDLE; cnt=0; ctrl_data_reg=0; rd_en_q=0; all outputs 0.
- Reset mid-frame: immediate return to IDLE. A descriptor already popped is discarded. No eop is generated.
- Outputs are combinational decodes of registered state/cnt/rd_en_q.
- FSM states and actions:
  - IDLE: if !desc_empty → SOP.
  - SOP: sop=1, desc_rd=1, ctrl_data_reg<=desc_data. → CTRL.
  - CTRL: data_out=ctrl_data_reg, valid=0. If L==0 → EOP, else → DATA.
  - DATA: rd_en=!tx_hold. cnt increments on rd_en. When rd_en && cnt==L-1 → DRAIN.
  - DRAIN: no new read; last beat is presented (valid=1 from rd_en_q). → EOP.
  - EOP: eop=1, valid=0. → DONE.
  - DONE: done=1, crc_rst=1, cnt<=0. → IDLE.
- valid: rd_en_q, a register of rd_en. When valid=1, data_out=rd_data.
- Hold: tx_hold blocks issue only. One beat already in flight still appears the cycle after hold rises; downstream tolerates this. Hold is ignored outside DATA.
- Beat count: exactly L valid beats per frame. cnt width is WIDTH_LENGTH and never wraps, since L ≤ DATA_LENGTH_MAX.
- Timing: desc_empty falls at cycle t → sop at t+1, ctrl at t+2, first rd_en at t+3. With no hold, eop at t+L+4, done at t+L+5, IDLE at t+L+6.
- Back-to-back frames: minimum 1 idle cycle between frames.

Optional Feature:
Macro: OUT_RD_LEN_CHECK_EN.
- Defined: in CTRL, if L==0 or L>`DATA_LENGTH_MAX, then err=1 for one cycle, crc_rst=1, and → IDLE. No data beats and no eop are sent. sop has already been sent, so the receiver sees an aborted frame and takes its own error path.
- Undefined: err tied 0. L==0 sends an empty frame (sop, ctrl, eop). The length field is taken modulo 2^WIDTH_LENGTH.

Decomposition:
- Shared package/header (generate_parameter.vh): DATA_WIDTH, DATA_LENGTH_MAX, derived WIDTH_LENGTH, and the state encodings as localparams.
- Natural sub-module: out_rd_beat_counter, holding cnt with clear/increment and the last-beat compare. Otherwise single module.

Test Plan:
- Reset, then descriptor L=3, no hold → sop t+1, ctrl word t+2, valid with rd_data at t+4..t+6, eop t+7, done t+8, crc_rst_n low t+8.
- L=5 with tx_hold high for 2 cycles after the 2nd read → exactly 5 valid beats, data order preserved, eop after the 5th beat.
- L=0, macro off → sop, ctrl, eop, done with zero valid beats. Macro on → err pulse, no eop, back in IDLE.
- Two descriptors queued (L=1, L=2) → two complete frames; desc_rd pulses exactly twice; second sop arrives 1 cycle after the first frame's IDLE.
- rst_n asserted during DATA of an L=8 frame → all outputs 0 immediately; after release, next queued descriptor sends a clean frame.
- L=`DATA_LENGTH_MAX → all beats sent, counter reaches L-1 without overflow, eop follows.
